// File: rtl/plic_seg_wrapper.sv
// rtl/plic_seg_wrapper.sv - push-button hex counter driving one active-low seven-segment digit
module plic_seg_wrapper #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int COUNT_WIDTH     = 4
) (
    input  logic CLK100MHZ,
    input  logic BTND,
    input  logic BTNC,
    output logic CA,
    output logic CB,
    output logic CC,
    output logic CD,
    output logic CE,
    output logic CF,
    output logic CG
);

    // Debounce counter is sized for the full 1..255 parameter range.
    localparam int              DB_W    = 8;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Segment bits are ordered {g,f,e,d,c,b,a}; the reset pattern shows "0".
    localparam logic [6:0] SEG_N_ZERO = 7'b1000000;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_db;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   w_mismatch;
    logic                   w_settle;
    logic                   r_db_prev;
    logic                   w_inc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [3:0]             w_digit;
    logic [6:0]             w_lit;
    logic [6:0]             r_seg_n;

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge CLK100MHZ or negedge BTND) begin
        if (!BTND) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], BTNC};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_sync ^ r_db;
    // The mismatch that brings the run up to DEBOUNCE_CYCLES is the one that flips the level.
    assign w_settle   = w_mismatch && (r_db_cnt == DB_LAST);

    // Count consecutive disagreeing cycles; flip the debounced level once the run is long enough.
    always_ff @(posedge CLK100MHZ or negedge BTND) begin
        if (!BTND) begin
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else if (!w_mismatch) begin
            r_db_cnt <= '0;
        end else if (w_settle) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Remember the previous debounced level so only a press (0->1) produces an increment.
    always_ff @(posedge CLK100MHZ or negedge BTND) begin
        if (!BTND) begin
            r_db_prev <= 1'b0;
        end else begin
            r_db_prev <= r_db;
        end
    end

    assign w_inc = r_db & ~r_db_prev;

    // Advance the counter once per press, wrapping naturally at the register width.
    always_ff @(posedge CLK100MHZ or negedge BTND) begin
        if (!BTND) begin
            r_count <= '0;
        end else if (w_inc) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    // Only the low nibble is displayed; COUNT_WIDTH is expected to be at least 4.
    assign w_digit = r_count[3:0];

    // Hex to lit-segment lookup, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        w_lit = 7'b0000000;
        case (w_digit)
            4'h0:    w_lit = 7'b0111111;
            4'h1:    w_lit = 7'b0000110;
            4'h2:    w_lit = 7'b1011011;
            4'h3:    w_lit = 7'b1001111;
            4'h4:    w_lit = 7'b1100110;
            4'h5:    w_lit = 7'b1101101;
            4'h6:    w_lit = 7'b1111101;
            4'h7:    w_lit = 7'b0000111;
            4'h8:    w_lit = 7'b1111111;
            4'h9:    w_lit = 7'b1101111;
            4'hA:    w_lit = 7'b1110111;
            4'hB:    w_lit = 7'b1111100;
            4'hC:    w_lit = 7'b0111001;
            4'hD:    w_lit = 7'b1011110;
            4'hE:    w_lit = 7'b1111001;
            4'hF:    w_lit = 7'b1110001;
            default: w_lit = 7'b0000000;
        endcase
    end

    // Register the inverted pattern so the pins are glitch-free and active-low.
    always_ff @(posedge CLK100MHZ or negedge BTND) begin
        if (!BTND) begin
            r_seg_n <= SEG_N_ZERO;
        end else begin
            r_seg_n <= ~w_lit;
        end
    end

    assign CA = r_seg_n[0];
    assign CB = r_seg_n[1];
    assign CC = r_seg_n[2];
    assign CD = r_seg_n[3];
    assign CE = r_seg_n[4];
    assign CF = r_seg_n[5];
    assign CG = r_seg_n[6];

endmodule

// File: tb/tb_plic_seg_wrapper.sv
// tb/tb_plic_seg_wrapper.sv - self-checking bench for plic_seg_wrapper
module tb_plic_seg_wrapper;

    localparam int S  = 2;
    localparam int D  = 3;
    localparam int CW = 4;

    logic CLK100MHZ;
    logic BTND;
    logic BTNC;
    logic CA, CB, CC, CD, CE, CF, CG;

    plic_seg_wrapper #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .COUNT_WIDTH    (CW)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .BTND     (BTND),
        .BTNC     (BTNC),
        .CA       (CA),
        .CB       (CB),
        .CC       (CC),
        .CD       (CD),
        .CE       (CE),
        .CF       (CF),
        .CG       (CG)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Pin vectors are {CG,CF,CE,CD,CC,CB,CA}.
    string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] pins(input int v);
        logic [6:0] p;
        string      s;
        p = 7'h7F;
        s = seg_str[v % 16];
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - int'("a")] = 1'b0;
        return p;
    endfunction

    function automatic logic [6:0] dut_pins();
        return {CG, CF, CE, CD, CC, CB, CA};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: raw samples delayed S cycles, level flips when the last D
    // samples seen since the previous flip all disagree with it; a press counts one
    // cycle later and the display follows one cycle after that.
    bit         pipe[$];
    bit         hist[$];
    bit         m_db;
    bit         m_inc;
    bit         seen;
    bit         all_diff;
    int         m_cnt;
    logic [6:0] m_seg;

    always @(posedge CLK100MHZ) begin
        if (!BTND) begin
            pipe.delete();
            for (int i = 0; i < S; i++) pipe.push_back(1'b0);
            hist.delete();
            m_db  = 1'b0;
            m_inc = 1'b0;
            m_cnt = 0;
            m_seg = pins(0);
        end else begin
            seen = pipe.pop_front();
            pipe.push_back(BTNC);
            m_seg = pins(m_cnt % 16);
            m_cnt = (m_cnt + int'(m_inc)) % (1 << CW);
            m_inc = 1'b0;
            hist.push_back(seen);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
                if (all_diff) begin
                    m_db  = ~m_db;
                    m_inc = m_db;
                    hist.delete();
                end
            end
        end
    end

    // Every-cycle comparison of the pins against the model.
    always @(posedge CLK100MHZ) begin
        #1;
        check("cycle", dut_pins(), m_seg);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic press(input int hi, input int lo);
        BTNC = 1'b1;
        idle(hi);
        BTNC = 1'b0;
        idle(lo);
    endtask

    task automatic do_reset();
        BTND = 1'b0;
        idle(1);
        BTND = 1'b1;
    endtask

    initial begin
        BTND = 1'b0;
        BTNC = 1'b0;
        idle(1);
        BTND = 1'b1;
        idle(20);
        check("reset_zero", dut_pins(), 7'b1000000);

        // Long hold gives a single increment.
        press(150, 150);
        check("hold_one", dut_pins(), 7'b1111001);

        // Async reset mid-count.
        press(20, 10);
        press(20, 10);
        check("pre_async_3", dut_pins(), 7'b0110000);
        #1 BTND = 1'b0;
        #1 check("async_reset", dut_pins(), 7'b1000000);
        idle(100);
        BTND = 1'b1;
        idle(10);
        check("after_async", dut_pins(), 7'b1000000);

        // Eight tight presses.
        for (int i = 1; i <= 8; i++) begin
            press(20, 4);
            check("eight_step", dut_pins(), pins(i));
        end
        check("eight_final", dut_pins(), 7'b0000000);

        // Sixteen presses wrap to zero; tenth shows A.
        do_reset();
        idle(5);
        for (int i = 1; i <= 16; i++) begin
            press(20, 4);
            if (i == 10) check("tenth_A", dut_pins(), 7'b0001000);
        end
        check("wrap_zero", dut_pins(), 7'b1000000);

        // Short glitches are ignored.
        idle(10);
        press(1, 10);
        check("glitch1", dut_pins(), 7'b1000000);
        press(2, 10);
        check("glitch2", dut_pins(), 7'b1000000);

        // Three-cycle press: display changes exactly S+D+2 edges after the rise.
        BTNC = 1'b1;
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        BTNC = 1'b0;
        repeat (S + D + 1 - 3) @(posedge CLK100MHZ);
        #1 check("latency_before", dut_pins(), 7'b1000000);
        @(posedge CLK100MHZ);
        #1 check("latency_after", dut_pins(), 7'b1111001);
        idle(20);

        // Randomised presses, bounces and occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            press(int'($urandom_range(1, 24)), int'($urandom_range(1, 24)));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
